transition_window_scheduler: RTL and testbench
==============================================

Name: transition_window_scheduler

Overview:
Measurement controller for multi-channel transition counting. On a start command it arms and clears CHANNELS per-channel transition counters. It then counts input transitions over a programmable window of clock cycles and streams each channel's result out over a valid/ready handshake. It sits between the control/CPU side, which issues start and window_len, and the monitored single-bit signals.

Parameters:
CHANNELS, 4, number of monitored single-bit inputs (2..16)
CNT_W, 16, width of each per-channel transition counter
WIN_W, 16, width of window length (cycles)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
in  input  CHANNELS  monitored signals, synchronous to clk
start  input  1  request a measurement; sampled only in IDLE
window_len  input  WIN_W  window length in cycles; latched on accepted start
busy  output  1  high from the cycle after an accepted start through the DONE state
out_valid  output  1  result word valid
out_ready  input  1  consumer accepts the result word
out_chan  output  clog2(CHANNELS)  channel index of the current result
out_count  output  CNT_W  transition count of out_chan
out_sat  output  1  out_count saturated during the window
done  output  1  one-cycle pulse after the last result is accepted

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE. busy, out_valid, done, out_chan, out_count and out_sat are 0. All counters, saturation flags, prev-sample regs and the remaining-cycle counter are 0.
- FSM states: IDLE, ARM, COUNT, DRAIN, DONE.
- IDLE: busy=0. start=1 at posedge moves to ARM and latches window_len into win_q.
- start is ignored in every state other than IDLE. No queuing.
- ARM (exactly 1 cycle): prev[i] <= in[i] for every channel, all counters and sat flags <= 0, remaining <= win_q. Next state is COUNT if win_q != 0, else DRAIN.
- COUNT: lasts exactly win_q cycles. Each cycle:
  - for each channel i with in[i] != prev[i]: counter[i] increments, then prev[i] <= in[i].
  - remaining decrements. Leave for DRAIN on the cycle remaining reaches 0.
  - A change and its reversal in adjacent cycles count as 2.
- Saturation: a counter at all-ones does not wrap. It holds all-ones and sets the sticky sat[i] flag.
- DRAIN: out_valid=1, out_chan=k, out_count=counter[k], out_sat=sat[k], starting at k=0.
  - Transfer occurs on a cycle with out_valid & out_ready. After a transfer k increments.
  - After the transfer at k=CHANNELS-1, go to DONE.
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - Inputs are not counted during DRAIN.
- DONE (1 cycle): done=1, busy=1, out_valid=0. Next state IDLE.
- Latency: start accepted at edge 0 gives ARM in cycle 1, COUNT in cycles 2..win_q+1, and the first out_valid in cycle win_q+2.
- window_len changes after acceptance have no effect on the measurement in progress.
- Reset asserted mid-operation aborts immediately to the reset values above. No done pulse, partial results discarded.
- out_count is always the full CNT_W counter value; out_* fields are 0 outside DRAIN.

Test Plan:
1. Reset with reset=0 while in toggling -> all outputs 0; after release, state IDLE, busy=0.
2. window_len=8, start; in[0] toggles every cycle, in[1] held constant, in[2] toggles once, in[3] toggles twice; out_ready=1 -> out_count sequence 8, 0, 1, 2; first out_valid 10 cycles after start edge; done pulses one cycle after chan 3 transfer.
3. CNT_W=4, window_len=40, in[0] toggling every cycle -> out_count=15, out_sat=1 for chan 0; other channels out_sat=0.
4. window_len=0, start -> ARM, then DRAIN directly; four results of 0; done pulse; no counting.
5. out_ready held 0 for 5 cycles during DRAIN on chan 1 -> out_chan=1 and out_count stable all 5 cycles; exactly CHANNELS transfers in total.
6. start pulsed during COUNT, plus reset=0 for one cycle mid-COUNT -> second start ignored; reset returns to IDLE with busy=0, no done; a fresh start then measures correctly.

Source files
------------

// File: rtl/transition_window_scheduler_if.sv
// Result stream of the transition window scheduler.
// One word per channel, moved on valid & ready.
interface transition_window_scheduler_if #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16
);
    localparam int CH_W = $clog2(CHANNELS);

    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_chan;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport master (
        output out_valid,
        output out_chan,
        output out_count,
        output out_sat,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_chan,
        input  out_count,
        input  out_sat,
        output out_ready
    );
endinterface

// File: rtl/transition_window_scheduler.sv
// Counts per-channel input transitions over a programmable window
// and streams one result word per channel.
module transition_window_scheduler #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 16,
    parameter int WIN_W    = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CHANNELS-1:0]  in,
    input  logic                 start,
    input  logic [WIN_W-1:0]     window_len,
    output logic                 busy,
    output logic                 done,
    transition_window_scheduler_if.master res
);
    localparam int CH_W = $clog2(CHANNELS);

    typedef enum logic [2:0] {
        IDLE, ARM, COUNT, DRAIN, DONE
    } state_t;

    state_t state, state_n;

    logic [WIN_W-1:0]    win_q;
    logic [WIN_W-1:0]    remaining;
    logic [CHANNELS-1:0] prev;
    logic [CHANNELS-1:0] sat;
    logic [CNT_W-1:0]    cnt [CHANNELS];
    logic [CH_W-1:0]     k;

    logic drain;
    logic xfer;
    logic last_k;

    assign drain  = (state == DRAIN);
    assign xfer   = drain & res.out_ready;
    assign last_k = (k == CH_W'(CHANNELS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (start) state_n = ARM;
            ARM:     state_n = (win_q != '0) ? COUNT : DRAIN;
            COUNT:   if (remaining == WIN_W'(1)) state_n = DRAIN;
            DRAIN:   if (xfer && last_k) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        busy          = (state != IDLE);
        done          = (state == DONE);
        res.out_valid = drain;
        res.out_chan  = drain ? k : '0;
        res.out_count = drain ? cnt[k] : '0;
        res.out_sat   = drain ? sat[k] : 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q     <= '0;
            remaining <= '0;
            prev      <= '0;
            sat       <= '0;
            k         <= '0;
            for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
        end else begin
            case (state)
                IDLE: if (start) win_q <= window_len;
                ARM: begin
                    prev      <= in;
                    sat       <= '0;
                    k         <= '0;
                    remaining <= win_q;
                    for (int i = 0; i < CHANNELS; i++) cnt[i] <= '0;
                end
                COUNT: begin
                    remaining <= remaining - WIN_W'(1);
                    prev      <= in;
                    // a lost increment at all-ones is what marks saturation
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (in[i] != prev[i]) begin
                            if (&cnt[i]) sat[i] <= 1'b1;
                            else         cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end
                end
                DRAIN: if (xfer && !last_k) k <= k + CH_W'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_transition_window_scheduler.sv
// Directed bench: a wide-counter and a 4-bit-counter instance
// share stimulus; each table row is one full measurement.
module tb_transition_window_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [3:0]  in_sig = 4'h0;
    logic        start = 1'b0;
    logic [15:0] window_len = 16'd0;
    logic        out_ready = 1'b1;
    logic        busy_w, done_w, busy_s, done_s;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    transition_window_scheduler_if #(.CHANNELS(4), .CNT_W(16)) bus_w ();
    transition_window_scheduler_if #(.CHANNELS(4), .CNT_W(4))  bus_s ();

    assign bus_w.out_ready = out_ready;
    assign bus_s.out_ready = out_ready;

    transition_window_scheduler #(.CHANNELS(4), .CNT_W(16), .WIN_W(16)) dut_w (
        .clk(clk), .reset(reset), .in(in_sig), .start(start),
        .window_len(window_len), .busy(busy_w), .done(done_w), .res(bus_w)
    );

    transition_window_scheduler #(.CHANNELS(4), .CNT_W(4), .WIN_W(16)) dut_s (
        .clk(clk), .reset(reset), .in(in_sig), .start(start),
        .window_len(window_len), .busy(busy_s), .done(done_s), .res(bus_s)
    );

    typedef struct packed {
        logic [15:0]      win;
        logic [3:0]       every;
        logic [3:0]       once;
        logic [3:0]       twice;
        logic             stall;
        logic             restart;
        logic [3:0][15:0] exp;
        logic [3:0][3:0]  exp_s;
        logic [3:0]       sat_s;
    } vec_t;

    vec_t tab [6];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int e, first_v, done_e, last_x, nx, stall_left, busy_bad, stall_bad;
        logic [15:0] hold_c;
        first_v = -1; done_e = -1; last_x = -1; nx = 0;
        busy_bad = 0; stall_bad = 0; hold_c = '0;
        stall_left = v.stall ? 5 : 0;
        window_len = v.win;
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        window_len = ~v.win;
        chk($sformatf("v%0d busy_after_start", idx), busy_w, 1);
        e = 0;
        while (e < 200 && done_e < 0) begin
            step();
            e++;
            in_sig ^= v.every;
            if (e == 3) in_sig ^= v.once;
            if (e == 2 || e == 5) in_sig ^= v.twice;
            if (v.restart && e == 4) begin
                start = 1'b1;
                window_len = 16'd3;
            end else begin
                start = 1'b0;
            end
            if (!busy_w) busy_bad++;
            if (done_w) begin
                done_e = e;
            end else begin
                if (bus_w.out_valid && first_v < 0) first_v = e;
                if (bus_w.out_valid && bus_w.out_chan == 2'd1 && stall_left > 0) begin
                    out_ready = 1'b0;
                    if (stall_left == 5) hold_c = bus_w.out_count;
                    else if (bus_w.out_count != hold_c) stall_bad++;
                    stall_left--;
                end else begin
                    if (stall_left > 0 && stall_left < 5) stall_bad++;
                    out_ready = 1'b1;
                end
                if (bus_w.out_valid && out_ready) begin
                    chk($sformatf("v%0d chan", idx), bus_w.out_chan, nx);
                    chk($sformatf("v%0d count[%0d]", idx, nx),
                        bus_w.out_count, v.exp[nx]);
                    chk($sformatf("v%0d sat[%0d]", idx, nx), bus_w.out_sat, 0);
                    chk($sformatf("v%0d count4[%0d]", idx, nx),
                        bus_s.out_count, v.exp_s[nx]);
                    chk($sformatf("v%0d sat4[%0d]", idx, nx),
                        bus_s.out_sat, v.sat_s[nx]);
                    last_x = e;
                    nx++;
                end
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
        chk($sformatf("v%0d done_seen", idx), (done_e >= 0), 1);
        chk($sformatf("v%0d transfers", idx), nx, 4);
        chk($sformatf("v%0d first_valid_edge", idx), first_v, v.win + 1);
        chk($sformatf("v%0d done_after_last", idx), done_e, last_x + 1);
        chk($sformatf("v%0d busy_held", idx), busy_bad, 0);
        if (v.stall) begin
            chk($sformatf("v%0d stall_stable", idx), stall_bad, 0);
            chk($sformatf("v%0d stall_done", idx), stall_left, 0);
        end
        step();
        chk($sformatf("v%0d done_one_cycle", idx), done_w, 0);
        chk($sformatf("v%0d idle_busy", idx), busy_w, 0);
    endtask

    initial begin
        tab[0] = '{win: 16'd8, every: 4'h1, once: 4'h4, twice: 4'h8,
                   stall: 1'b0, restart: 1'b0,
                   exp: {16'd2, 16'd1, 16'd0, 16'd8},
                   exp_s: {4'd2, 4'd1, 4'd0, 4'd8}, sat_s: 4'b0000};
        tab[1] = '{win: 16'd40, every: 4'h1, once: 4'h0, twice: 4'h0,
                   stall: 1'b0, restart: 1'b0,
                   exp: {16'd0, 16'd0, 16'd0, 16'd40},
                   exp_s: {4'd0, 4'd0, 4'd0, 4'd15}, sat_s: 4'b0001};
        tab[2] = '{win: 16'd0, every: 4'hF, once: 4'h0, twice: 4'h0,
                   stall: 1'b0, restart: 1'b0,
                   exp: {16'd0, 16'd0, 16'd0, 16'd0},
                   exp_s: {4'd0, 4'd0, 4'd0, 4'd0}, sat_s: 4'b0000};
        tab[3] = '{win: 16'd1, every: 4'h3, once: 4'h4, twice: 4'h8,
                   stall: 1'b0, restart: 1'b0,
                   exp: {16'd0, 16'd0, 16'd1, 16'd1},
                   exp_s: {4'd0, 4'd0, 4'd1, 4'd1}, sat_s: 4'b0000};
        tab[4] = '{win: 16'd4, every: 4'hA, once: 4'h1, twice: 4'h4,
                   stall: 1'b1, restart: 1'b0,
                   exp: {16'd4, 16'd1, 16'd4, 16'd1},
                   exp_s: {4'd4, 4'd1, 4'd4, 4'd1}, sat_s: 4'b0000};
        tab[5] = '{win: 16'd16, every: 4'hF, once: 4'h0, twice: 4'h0,
                   stall: 1'b0, restart: 1'b1,
                   exp: {16'd16, 16'd16, 16'd16, 16'd16},
                   exp_s: {4'd15, 4'd15, 4'd15, 4'd15}, sat_s: 4'b1111};

        // reset held while inputs toggle
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            in_sig ^= 4'hF;
            start = 1'b1;
        end
        start = 1'b0;
        chk("rst busy", busy_w, 0);
        chk("rst done", done_w, 0);
        chk("rst valid", bus_w.out_valid, 0);
        chk("rst chan", bus_w.out_chan, 0);
        chk("rst count", bus_w.out_count, 0);
        chk("rst sat", bus_w.out_sat, 0);
        reset = 1'b1;
        step();
        step();
        chk("post_rst busy", busy_w, 0);
        chk("post_rst valid", bus_w.out_valid, 0);

        for (int i = 0; i < 6; i++) run_vec(i, tab[i]);

        // abort mid-COUNT with an asynchronous reset
        begin
            int done_hits;
            done_hits = 0;
            window_len = 16'd20;
            start = 1'b1;
            step();
            start = 1'b0;
            for (int i = 0; i < 4; i++) begin
                step();
                in_sig ^= 4'h5;
            end
            chk("abort busy_before", busy_w, 1);
            reset = 1'b0;
            #1;
            chk("abort busy_async", busy_w, 0);
            chk("abort valid_async", bus_w.out_valid, 0);
            step();
            reset = 1'b1;
            for (int i = 0; i < 25; i++) begin
                step();
                if (done_w || busy_w) done_hits++;
            end
            chk("abort no_done", done_hits, 0);
        end

        run_vec(6, tab[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
